// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with a loadable pattern,
// overlap control and a saturating, clearable match counter.
module seq_detect_param #(
    parameter int             N        = 4,
    parameter int             OVERLAP  = 1,
    parameter int             CNT_W    = 8,
    parameter logic [N-1:0]   PAT_INIT = 4'b1011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic [N-1:0]     pattern
);

    localparam int               FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam bit               RESTART   = (OVERLAP == 0);

    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_pat;

    logic [N-1:0]     w_hist_shift;
    logic [FW-1:0]    w_fill_inc;
    logic             w_full_next;
    logic             w_match;

    // Next window contents and the match decision for this edge; a load
    // discards the sample, so it can never produce a match.
    always_comb begin
        w_hist_shift = {r_hist[N-2:0], x};
        w_fill_inc   = r_fill;
        if (r_fill != FILL_FULL) begin
            w_fill_inc = r_fill + FW'(1);
        end
        w_full_next  = (w_fill_inc == FILL_FULL);
        w_match      = en && !load && w_full_next &&
                       (w_hist_shift == r_pat);
    end

    // Sample window and fill level; a non-overlapping match restarts it.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (en) begin
            if (w_match && RESTART) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_hist_shift;
                r_fill <= w_fill_inc;
            end
        end
    end

    // Registered one-cycle match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    // Saturating match counter; a clear wins over a same-edge match.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Active pattern register, replaced on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat <= PAT_INIT;
        end else if (load) begin
            r_pat <= pat_in;
        end
    end

    assign out       = r_out;
    assign match_cnt = r_cnt;
    assign pattern   = r_pat;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: three detector variants driven by shared stimulus,
// each compared against a queue-based model of accepted samples.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, en, x, load, clr_cnt;
    logic [3:0] pat_in;

    logic       out_a, out_b, out_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [3:0] pat_a, pat_b, pat_c;

    always #5 clk = ~clk;

    seq_detect_param #(.N(4), .OVERLAP(1), .CNT_W(8), .PAT_INIT(4'b1011)) dut_a (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .out(out_a), .match_cnt(cnt_a), .pattern(pat_a));

    seq_detect_param #(.N(4), .OVERLAP(0), .CNT_W(8), .PAT_INIT(4'b1011)) dut_b (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .out(out_b), .match_cnt(cnt_b), .pattern(pat_b));

    seq_detect_param #(.N(4), .OVERLAP(1), .CNT_W(2), .PAT_INIT(4'b1011)) dut_c (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .out(out_c), .match_cnt(cnt_c), .pattern(pat_c));

    logic [31:0] oo [3];
    logic [31:0] oc [3];
    logic [31:0] op [3];

    assign oo[0] = {31'b0, out_a};
    assign oo[1] = {31'b0, out_b};
    assign oo[2] = {31'b0, out_c};
    assign oc[0] = {24'b0, cnt_a};
    assign oc[1] = {24'b0, cnt_b};
    assign oc[2] = {30'b0, cnt_c};
    assign op[0] = {28'b0, pat_a};
    assign op[1] = {28'b0, pat_b};
    assign op[2] = {28'b0, pat_c};

    int checks = 0;
    int errors = 0;

    bit       ovl  [3] = '{1'b1, 1'b0, 1'b1};
    int       cmax [3] = '{255, 255, 3};
    bit       mq   [3][$];
    int       mcnt [3];
    logic [3:0] mpat [3];
    bit       mout [3];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit xi, input bit ld,
                         input logic [3:0] pin, input bit clr);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mq[k].delete();
                mcnt[k] = 0;
                mout[k] = 1'b0;
                mpat[k] = 4'b1011;
            end else if (ld) begin
                mq[k].delete();
                mpat[k] = pin;
                mout[k] = 1'b0;
                if (clr) mcnt[k] = 0;
            end else begin
                bit hit;
                hit = 1'b0;
                if (e) begin
                    mq[k].push_back(xi);
                    if (mq[k].size() > 4) void'(mq[k].pop_front());
                    if (mq[k].size() == 4 &&
                        {mq[k][0], mq[k][1], mq[k][2], mq[k][3]} == mpat[k])
                        hit = 1'b1;
                    if (hit && !ovl[k]) mq[k].delete();
                end
                mout[k] = hit;
                if (clr) mcnt[k] = 0;
                else if (hit && mcnt[k] < cmax[k]) mcnt[k]++;
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input bit xi, input bit ld,
                        input logic [3:0] pin, input bit clr);
        rst = r; en = e; x = xi; load = ld; pat_in = pin; clr_cnt = clr;
        model(r, e, xi, ld, pin, clr);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out%0d", k), oo[k], {31'b0, mout[k]});
            check($sformatf("cnt%0d", k), oc[k], mcnt[k]);
            check($sformatf("pat%0d", k), op[k], {28'b0, mpat[k]});
        end
    endtask

    task automatic sample(input bit b);
        step(1'b0, 1'b1, b, 1'b0, 4'h0, 1'b0);
    endtask

    logic [6:0]  s030 = 7'b1011011;
    logic [15:0] s035 = 16'b1011011011011011;

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0;
        load = 1'b0; pat_in = 4'h0; clr_cnt = 1'b0;

        step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        check("rst_pattern", op[0], 32'd11);
        check("rst_cnt", oc[0], 32'd0);

        for (int i = 6; i >= 0; i--) sample(s030[i]);
        check("ovl_cnt", oc[0], 32'd2);
        check("novl_cnt", oc[1], 32'd1);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        sample(1'b1);
        sample(1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 4'h0, 1'b0);
        sample(1'b1);
        check("gap_nopulse", oo[0], 32'd0);
        sample(1'b1);
        check("gap_pulse", oo[0], 32'd1);

        sample(1'b1);
        sample(1'b0);
        sample(1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
        sample(1'b1);
        check("post_rst_first", oo[0], 32'd0);
        sample(1'b0);
        sample(1'b1);
        sample(1'b1);
        check("post_rst_pulse", oo[0], 32'd1);

        step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0);
        check("load_pattern", op[0], 32'd0);
        check("load_cnt_kept", oc[0], 32'd1);
        for (int i = 0; i < 3; i++) sample(1'b0);
        check("load_nopulse", oo[0], 32'd0);
        sample(1'b0);
        check("load_pulse", oo[0], 32'd1);

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 15; i >= 1; i--) begin
            sample(s035[i]);
            if (i == 3) check("sat_cnt_m4", oc[2], 32'd3);
        end
        step(1'b0, 1'b1, s035[0], 1'b0, 4'h0, 1'b1);
        check("clr_out", oo[2], 32'd1);
        check("clr_cnt", oc[2], 32'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(3) != 0,
                 1'($urandom_range(1)),
                 $urandom_range(39) == 0,
                 4'($urandom_range(15)),
                 $urandom_range(29) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
